// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_boot_loader.
// The loader sits on the slave modport; the stream source and memory use master.
interface imem_boot_loader_if #(
    parameter int unsigned WORD_ADDR_WIDTH = 8
);
    logic [7:0]                 s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic                       imem_we;
    logic [WORD_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_wdata;

    modport master (
        output s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: writes big-endian words into instruction memory and
// holds the pipeline in reset until done. Define BOOT_CHECKSUM_EN for the trailing XOR check byte.
module imem_boot_loader #(
    parameter int unsigned WORD_ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    imem_boot_loader_if.slave bus,
    output logic              core_reset,
    output logic              done,
    output logic              error
);
    localparam int unsigned DEPTH = 1 << WORD_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_FINISH,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_cnt_hi;
    logic [WORD_ADDR_WIDTH-1:0] r_word_idx;
    logic [WORD_ADDR_WIDTH-1:0] r_last_idx;
    logic [1:0]                 r_byte;
    logic [23:0]                r_shift;
    logic                       r_s_ready;
    logic                       r_imem_we;
    logic [WORD_ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]                r_imem_wdata;
    logic                       r_core_reset;
    logic                       r_done;
    logic                       r_error;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]                 r_csum;
`endif

    logic        w_xfer;
    logic [15:0] w_count;
    logic        w_too_big;

    assign w_xfer    = bus.s_valid && r_s_ready;
    assign w_count   = {r_cnt_hi, bus.s_data};
    assign w_too_big = 32'(w_count) > DEPTH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HDR0;
            r_cnt_hi     <= '0;
            r_word_idx   <= '0;
            r_last_idx   <= '0;
            r_byte       <= '0;
            r_shift      <= '0;
            r_s_ready    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            if (w_xfer && r_state != S_CHK) r_csum <= r_csum ^ bus.s_data;
`endif
            case (r_state)
                S_HDR0: begin
                    r_s_ready <= 1'b1;
                    if (w_xfer) begin
                        r_cnt_hi <= bus.s_data;
                        r_state  <= S_HDR1;
                    end
                end
                S_HDR1: if (w_xfer) begin
                    // last index is only meaningful when 1 <= N <= DEPTH
                    r_last_idx <= WORD_ADDR_WIDTH'(w_count - 16'd1);
                    if (w_too_big) begin
                        r_state   <= S_ERR;
                        r_s_ready <= 1'b0;
                        r_error   <= 1'b1;
                    end else if (w_count == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        r_state      <= S_CHK;
`else
                        r_state      <= S_RUN;
                        r_s_ready    <= 1'b0;
                        r_core_reset <= 1'b0;
                        r_done       <= 1'b1;
`endif
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: if (w_xfer) begin
                    r_byte <= r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_idx;
                        r_imem_wdata <= {r_shift, bus.s_data};
                        if (r_word_idx == r_last_idx) begin
                            r_state   <= S_FINISH;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_word_idx <= r_word_idx + WORD_ADDR_WIDTH'(1);
                        end
                    end else begin
                        r_shift <= {r_shift[15:0], bus.s_data};
                    end
                end
                S_FINISH: begin
`ifdef BOOT_CHECKSUM_EN
                    r_state      <= S_CHK;
                    r_s_ready    <= 1'b1;
`else
                    r_state      <= S_RUN;
                    r_core_reset <= 1'b0;
                    r_done       <= 1'b1;
`endif
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHK: if (w_xfer) begin
                    r_s_ready <= 1'b0;
                    if (bus.s_data == r_csum) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                    end
                end
`endif
                S_RUN, S_ERR: r_s_ready <= 1'b0;
                default: begin
                    r_state   <= S_ERR;
                    r_s_ready <= 1'b0;
                    r_error   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign core_reset     = r_core_reset;
    assign done           = r_done;
    assign error          = r_error;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_imem_boot_loader;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 256;
`ifdef BOOT_CHECKSUM_EN
    localparam int unsigned REL_LAT = 0;
`else
    localparam int unsigned REL_LAT = 1;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [39:0] wr_q_t[$];
    typedef int unsigned edge_q_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic core_reset, done, error;

    imem_boot_loader_if #(.WORD_ADDR_WIDTH(W)) bus ();

    imem_boot_loader #(.WORD_ADDR_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    int unsigned edge_n = 0;
    wr_q_t       wr_log;
    edge_q_t     wr_edge;
    edge_q_t     acc_edge;
    byte_q_t     acc_data;
    int unsigned done_edge, err_edge;
    bit          done_seen, err_seen;

    always @(posedge clk) begin
        edge_n++;
        if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
            acc_edge.push_back(edge_n);
            acc_data.push_back(bus.s_data);
        end
    end

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_log.push_back({bus.imem_addr, bus.imem_wdata});
            wr_edge.push_back(edge_n);
        end
        if (done === 1'b1 && !done_seen) begin done_seen = 1'b1; done_edge = edge_n; end
        if (error === 1'b1 && !err_seen) begin err_seen = 1'b1; err_edge = edge_n; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Frame-level reference: what a correct loader writes and how the frame ends.
    function automatic void model(input byte_q_t f, output wr_q_t w, output int unsigned nacc,
                                  output bit d, output bit e);
        int unsigned n;
        w = {};
        d = 1'b0;
        e = 1'b0;
        n = f[0] * 256 + f[1];
        if (n > DEPTH) begin
            nacc = 2;
            e    = 1'b1;
            return;
        end
        for (int unsigned i = 0; i < n; i++)
            w.push_back({8'(i), f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]});
        nacc = 2 + 4 * n;
`ifdef BOOT_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = '0;
            for (int unsigned i = 0; i < nacc; i++) x = x ^ f[i];
            if (f[nacc] == x) d = 1'b1;
            else e = 1'b1;
            nacc++;
        end
`else
        d = 1'b1;
`endif
    endfunction

    function automatic byte_q_t make_frame(input int unsigned n, input bit good_chk);
        byte_q_t f;
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        for (int unsigned i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
`ifdef BOOT_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = '0;
            foreach (f[i]) x = x ^ f[i];
            f.push_back(good_chk ? x : ~x);
        end
`else
        if (good_chk) f.push_back(8'h00);
        if (good_chk) void'(f.pop_back());
`endif
        return f;
    endfunction

    function automatic byte_q_t basic_frame(input logic [7:0] chk);
        byte_q_t f;
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef BOOT_CHECKSUM_EN
        f.push_back(chk);
`else
        if (chk == 8'hFF) f.push_back(chk);
`endif
        return f;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        wr_edge.delete();
        acc_edge.delete();
        acc_data.delete();
        done_seen = 1'b0;
        err_seen  = 1'b0;
        done_edge = 0;
        err_edge  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred (or timed out).
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int unsigned t;
        t = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.s_ready === 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
    endtask

    task automatic send_frame(input byte_q_t f, input int unsigned gmin, input int unsigned gmax);
        bit ok;
        foreach (f[i]) begin
            send_byte(f[i], ok);
            if (!ok) break;
            repeat ($urandom_range(gmax, gmin)) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({bus.s_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== 42'h0) begin
            n_err++;
            $display("FAIL reset_bus: got ready=%b we=%b addr=%h wdata=%h, expected all 0",
                     bus.s_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        n_chk++;
        if ({core_reset, done, error} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_status: got core_reset/done/error=%b, expected 100", {core_reset, done, error});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: got s_ready=%b, expected 1", bus.s_ready);
        end
    endtask

    task automatic test_basic();
        logic [39:0] w0, w1;
        do_reset();
        send_frame(basic_frame(8'h01), 0, 0);
        settle();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 'x;
        w1 = (wr_log.size() > 1) ? wr_log[1] : 'x;
        n_chk++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL basic_count: got %0d writes, expected 2", wr_log.size());
        end
        n_chk++;
        if (w0 !== 40'h00_20080005 || w1 !== 40'h01_20090007) begin
            n_err++;
            $display("FAIL basic_data: got %h %h, expected 0020080005 0120090007", w0, w1);
        end
        n_chk++;
        if ({core_reset, done, error, bus.s_ready} !== 4'b0100) begin
            n_err++;
            $display("FAIL basic_status: got core_reset/done/error/ready=%b, expected 0100",
                     {core_reset, done, error, bus.s_ready});
        end
        n_chk++;
        if (wr_edge.size() < 2 || acc_edge.size() < 10 ||
            wr_edge[0] != acc_edge[5] || wr_edge[1] != acc_edge[9]) begin
            n_err++;
            $display("FAIL basic_write_timing: write edges not one cycle after 4th byte (writes=%0d bytes=%0d)",
                     wr_edge.size(), acc_edge.size());
        end
        n_chk++;
        if (!done_seen || acc_edge.size() == 0 ||
            done_edge != acc_edge[acc_edge.size()-1] + REL_LAT) begin
            n_err++;
            $display("FAIL basic_release_timing: got done edge %0d, expected %0d", done_edge,
                     (acc_edge.size() == 0) ? 0 : acc_edge[acc_edge.size()-1] + REL_LAT);
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] w0, w1;
        do_reset();
        send_frame(basic_frame(8'h01), 3, 3);
        settle();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 'x;
        w1 = (wr_log.size() > 1) ? wr_log[1] : 'x;
        n_chk++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL bp_count: got %0d writes, expected 2", wr_log.size());
        end
        n_chk++;
        if (w0 !== 40'h00_20080005 || w1 !== 40'h01_20090007) begin
            n_err++;
            $display("FAIL bp_data: got %h %h, expected 0020080005 0120090007", w0, w1);
        end
        n_chk++;
        if ({core_reset, done, error} !== 3'b010) begin
            n_err++;
            $display("FAIL bp_status: got core_reset/done/error=%b, expected 010", {core_reset, done, error});
        end
    endtask

    task automatic test_empty();
        byte_q_t f;
        f = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        do_reset();
        send_frame(f, 0, 1);
        settle();
        n_chk++;
        if (wr_log.size() != 0 || {core_reset, done, error} !== 3'b010) begin
            n_err++;
            $display("FAIL empty: got writes=%0d core_reset/done/error=%b, expected 0 and 010",
                     wr_log.size(), {core_reset, done, error});
        end
        n_chk++;
        if (!done_seen || acc_edge.size() == 0 || done_edge != acc_edge[acc_edge.size()-1]) begin
            n_err++;
            $display("FAIL empty_timing: got done edge %0d, expected one cycle after last byte", done_edge);
        end
    endtask

    task automatic test_overflow();
        byte_q_t f;
        f = '{8'h01, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
        do_reset();
        send_frame(f, 0, 0);
        settle();
        n_chk++;
        if (acc_data.size() != 2 || wr_log.size() != 0) begin
            n_err++;
            $display("FAIL overflow_accept: got accepted=%0d writes=%0d, expected 2 and 0",
                     acc_data.size(), wr_log.size());
        end
        n_chk++;
        if ({core_reset, done, error, bus.s_ready} !== 4'b1010) begin
            n_err++;
            $display("FAIL overflow_status: got core_reset/done/error/ready=%b, expected 1010",
                     {core_reset, done, error, bus.s_ready});
        end
        n_chk++;
        if (!err_seen || acc_edge.size() < 2 || err_edge != acc_edge[1]) begin
            n_err++;
            $display("FAIL overflow_timing: got error edge %0d, expected cycle after count byte", err_edge);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_bad_checksum();
        do_reset();
        send_frame(basic_frame(8'h00), 0, 1);
        settle();
        n_chk++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL badchk_count: got %0d writes, expected 2", wr_log.size());
        end
        n_chk++;
        if ({core_reset, done, error} !== 3'b101) begin
            n_err++;
            $display("FAIL badchk_status: got core_reset/done/error=%b, expected 101", {core_reset, done, error});
        end
    endtask
`endif

    task automatic test_full_depth();
        byte_q_t     f;
        wr_q_t       exp_wr;
        int unsigned exp_acc, bad;
        bit          exp_done, exp_err;
        f = make_frame(DEPTH, 1'b1);
        model(f, exp_wr, exp_acc, exp_done, exp_err);
        do_reset();
        send_frame(f, 0, 0);
        settle();
        bad = 0;
        foreach (exp_wr[i]) if (i >= wr_log.size() || wr_log[i] !== exp_wr[i]) bad++;
        n_chk++;
        if (wr_log.size() != DEPTH || bad != 0) begin
            n_err++;
            $display("FAIL full_depth_writes: got %0d writes with %0d mismatches, expected %0d exact",
                     wr_log.size(), bad, DEPTH);
        end
        n_chk++;
        if (wr_log.size() == 0 || wr_log[wr_log.size()-1][39:32] !== 8'hFF) begin
            n_err++;
            $display("FAIL full_depth_last_addr: got last write %h, expected addr ff",
                     (wr_log.size() == 0) ? 40'h0 : wr_log[wr_log.size()-1]);
        end
        n_chk++;
        if ({core_reset, done, error} !== 3'b010) begin
            n_err++;
            $display("FAIL full_depth_status: got core_reset/done/error=%b, expected 010", {core_reset, done, error});
        end
    endtask

    task automatic test_random();
        byte_q_t     f;
        wr_q_t       exp_wr;
        int unsigned exp_acc, n, gmax, bad;
        bit          exp_done, exp_err;
        for (int unsigned it = 0; it < 12; it++) begin
            n    = $urandom_range(12, 0);
            gmax = $urandom_range(2, 0);
            if ($urandom_range(5, 0) == 0) n = $urandom_range(300, DEPTH + 1);
            f = make_frame(n, $urandom_range(3, 0) != 0);
            model(f, exp_wr, exp_acc, exp_done, exp_err);
            do_reset();
            send_frame(f, 0, gmax);
            settle();
            bad = 0;
            foreach (exp_wr[i]) if (i >= wr_log.size() || wr_log[i] !== exp_wr[i]) bad++;
            n_chk++;
            if (wr_log.size() != exp_wr.size() || bad != 0) begin
                n_err++;
                $display("FAIL random_writes[%0d]: got %0d writes with %0d mismatches, expected %0d",
                         it, wr_log.size(), bad, exp_wr.size());
            end
            n_chk++;
            if (acc_data.size() != exp_acc) begin
                n_err++;
                $display("FAIL random_accepted[%0d]: got %0d bytes, expected %0d", it, acc_data.size(), exp_acc);
            end
            n_chk++;
            if ({done, error, core_reset, bus.s_ready} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
                n_err++;
                $display("FAIL random_status[%0d]: got done/error/core_reset/ready=%b, expected %b", it,
                         {done, error, core_reset, bus.s_ready}, {exp_done, exp_err, !exp_done, 1'b0});
            end
        end
    endtask

    task automatic test_midload_reset();
        byte_q_t     f;
        bit          ok;
        logic [39:0] w0;
        f = basic_frame(8'h01);
        do_reset();
        for (int unsigned i = 0; i < 5; i++) send_byte(f[i], ok);
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_we, bus.s_ready, core_reset, done} !== 4'b0010) begin
            n_err++;
            $display("FAIL midreset_abort: got we/ready/core_reset/done=%b, expected 0010",
                     {bus.imem_we, bus.s_ready, core_reset, done});
        end
        @(negedge clk);
        reset = 1'b1;
        n_chk++;
        if (wr_log.size() != 0) begin
            n_err++;
            $display("FAIL midreset_early_write: got %0d writes before replay, expected 0", wr_log.size());
        end
        clear_logs();
        send_frame(f, 0, 0);
        settle();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 'x;
        n_chk++;
        if (w0 !== 40'h00_20080005 || wr_log.size() != 2 || done !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_replay: got first write %h count %0d done %b, expected 0020080005 2 1",
                     w0, wr_log.size(), done);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        clear_logs();
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_overflow();
`ifdef BOOT_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_full_depth();
        test_random();
        test_midload_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
